// File: rtl/playfield_pkg.sv
// playfield_pkg: shared types and helpers for the playfield renderer.
//   shape_t     - piece shape encoding (bar, square, T, L)
//   state_t     - lock / row-clear FSM states
//   offs_t      - signed cell offset from the piece anchor
//   footprint() - (shape, rot, idx) -> offset of footprint cell idx (0..3)
//   palette()   - palette index -> 12-bit RGB
package playfield_pkg;

   typedef enum logic [1:0] {SH_BAR, SH_SQUARE, SH_T, SH_L} shape_t;
   typedef enum logic [2:0] {ST_IDLE, ST_LOCK, ST_SCAN, ST_SHIFT, ST_DONE} state_t;

   typedef struct packed {
      logic signed [2:0] dx;
      logic signed [2:0] dy;
   } offs_t;

   localparam logic [11:0] EMPTY_RGB   = 12'h222;
   localparam logic [11:0] OUTSIDE_RGB = 12'h000;

   function automatic offs_t footprint(input shape_t shape, input logic [1:0] rot,
                                       input logic [1:0] idx);
      offs_t             o;
      logic signed [2:0] arm;
      arm  = $signed({1'b0, idx}) - 3'sd1;   // -1, 0, 1, 2 along the long axis
      o.dx = '0;
      o.dy = '0;
      case (shape)
         SH_BAR: if (rot[0]) o.dy = arm; else o.dx = arm;
         SH_SQUARE: begin
            o.dx = {2'b00, idx[0]};
            o.dy = {2'b00, idx[1]};
         end
         default: begin
            // T and L share a three-cell arm through the anchor; cell 3 is the nub
            if (idx != 2'd3) begin
               if (rot[0]) o.dy = arm; else o.dx = arm;
            end else if (shape == SH_T) begin
               case (rot)
                  2'd0:    o.dy = 3'sd1;
                  2'd1:    o.dx = -3'sd1;
                  2'd2:    o.dy = -3'sd1;
                  default: o.dx = 3'sd1;
               endcase
            end else begin
               o.dx = (rot == 2'd0 || rot == 2'd3) ? 3'sd1 : -3'sd1;
               o.dy = rot[1] ? -3'sd1 : 3'sd1;
            end
         end
      endcase
      return o;
   endfunction

   function automatic logic [11:0] palette(input logic [2:0] idx);
      case (idx)
         3'd1:    return 12'hF00;
         3'd2:    return 12'h0F0;
         3'd3:    return 12'h00F;
         3'd4:    return 12'hFF0;
         3'd5:    return 12'h0FF;
         3'd6:    return 12'hF0F;
         3'd7:    return 12'hFFF;
         default: return 12'h000;
      endcase
   endfunction

endpackage

// File: rtl/piece_footprint.sv
// piece_footprint: combinational hit test of one grid cell against a piece.
//   anchor_x/anchor_y - piece anchor cell
//   shape/rot         - piece shape and rotation
//   cell_x/cell_y     - cell under test
//   hit               - cell is one of the four footprint cells
// Off-grid footprint cells can never equal an in-grid cell, so they drop out.
module piece_footprint
   import playfield_pkg::*;
#(
   parameter int XW = 4,
   parameter int YW = 5
) (
   input  logic [XW-1:0] anchor_x,
   input  logic [YW-1:0] anchor_y,
   input  shape_t        shape,
   input  logic [1:0]    rot,
   input  logic [XW-1:0] cell_x,
   input  logic [YW-1:0] cell_y,
   output logic          hit
);

   offs_t o;

   always_comb begin
      hit = 1'b0;
      o   = '0;
      for (int i = 0; i < 4; i++) begin
         o = footprint(shape, rot, 2'(i));
         if ((int'(anchor_x) + int'(o.dx) == int'(cell_x)) &&
             (int'(anchor_y) + int'(o.dy) == int'(cell_y)))
            hit = 1'b1;
      end
   end

endmodule

// File: rtl/playfield_renderer.sv
// playfield_renderer: settled-cell playfield with lock / row-clear FSM and a
// 2-stage pixel renderer.
//   Clk, Reset_n         - clock, async active-low reset
//   DrawX, DrawY         - current VGA pixel
//   piece_*              - live falling piece (anchor, shape, rotation, colour)
//   lock_req, clear_grid - commit piece to grid / wipe grid
//   lock_ack, busy       - lock+clear complete pulse / FSM not idle
//   lock_overrun         - sticky: lock_req arrived while busy
//   lines_cleared        - wrapping count of cleared rows
//   Red, Green, Blue     - registered pixel colour, 2 Clk after DrawX/DrawY
module playfield_renderer
   import playfield_pkg::*;
#(
   parameter int GRID_W   = 10,
   parameter int GRID_H   = 20,
   parameter int CELL_PX  = 16,
   parameter int ORIGIN_X = 240,
   parameter int ORIGIN_Y = 80,
   parameter int COLOR_W  = 3
) (
   input  logic                       Clk,
   input  logic                       Reset_n,
   input  logic [9:0]                 DrawX,
   input  logic [9:0]                 DrawY,
   input  logic [$clog2(GRID_W)-1:0]  piece_x,
   input  logic [$clog2(GRID_H)-1:0]  piece_y,
   input  logic [1:0]                 piece_shape,
   input  logic [1:0]                 piece_rot,
   input  logic [COLOR_W-1:0]         piece_color,
   input  logic                       lock_req,
   input  logic                       clear_grid,
   output logic                       lock_ack,
   output logic                       busy,
   output logic                       lock_overrun,
   output logic [15:0]                lines_cleared,
   output logic [3:0]                 Red,
   output logic [3:0]                 Green,
   output logic [3:0]                 Blue
);

   localparam int XW  = $clog2(GRID_W);
   localparam int YW  = $clog2(GRID_H);
   localparam int CSH = $clog2(CELL_PX);
   localparam logic [10:0] X_LO = 11'(ORIGIN_X);
   localparam logic [10:0] X_HI = 11'(ORIGIN_X + GRID_W * CELL_PX);
   localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
   localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + GRID_H * CELL_PX);

   typedef struct packed {
      shape_t             shape;
      logic [1:0]         rot;
      logic [XW-1:0]      x;
      logic [YW-1:0]      y;
      logic [COLOR_W-1:0] color;
   } piece_t;

   logic [GRID_H-1:0][GRID_W-1:0][COLOR_W-1:0] grid;
   state_t        state;
   piece_t        lk;
   logic [1:0]    lk_idx;
   logic [YW-1:0] row;

   assign busy = (state != ST_IDLE);

   // ---------------- render pipeline ----------------
   logic          in_field_d, in_field_q;
   logic [9:0]    rel_x, rel_y;
   logic [XW-1:0] cx_q;
   logic [YW-1:0] cy_q;
   logic          piece_hit;
   logic [COLOR_W-1:0] cell_val;
   logic [11:0]   rgb_d;

   assign rel_x      = DrawX - 10'(ORIGIN_X);
   assign rel_y      = DrawY - 10'(ORIGIN_Y);
   assign in_field_d = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI) &&
                       ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         in_field_q <= 1'b0;
         cx_q       <= '0;
         cy_q       <= '0;
      end else begin
         in_field_q <= in_field_d;
         cx_q       <= XW'(rel_x >> CSH);
         cy_q       <= YW'(rel_y >> CSH);
      end
   end

   piece_footprint #(.XW(XW), .YW(YW)) u_live_fp (
      .anchor_x (piece_x),
      .anchor_y (piece_y),
      .shape    (shape_t'(piece_shape)),
      .rot      (piece_rot),
      .cell_x   (cx_q),
      .cell_y   (cy_q),
      .hit      (piece_hit)
   );

   always_comb begin
      cell_val = grid[cy_q][cx_q];
      rgb_d    = OUTSIDE_RGB;
      if (in_field_q) begin
         // the live piece is only meaningful while no lock is in progress
         if (state == ST_IDLE && piece_color != '0 && piece_hit)
            rgb_d = palette(3'(piece_color));
         else if (cell_val != '0)
            rgb_d = palette(3'(cell_val));
         else
            rgb_d = EMPTY_RGB;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) {Red, Green, Blue} <= '0;
      else          {Red, Green, Blue} <= rgb_d;
   end

   // ---------------- lock / row-clear FSM ----------------
   offs_t         lk_off;
   int            lk_xi, lk_yi;
   logic          lk_ok;
   logic          row_full;

   always_comb begin
      lk_off = footprint(lk.shape, lk.rot, lk_idx);
      lk_xi  = int'(lk.x) + int'(lk_off.dx);
      lk_yi  = int'(lk.y) + int'(lk_off.dy);
      lk_ok  = (lk_xi >= 0) && (lk_xi < GRID_W) && (lk_yi >= 0) && (lk_yi < GRID_H);
   end

   always_comb begin
      row_full = 1'b1;
      for (int c = 0; c < GRID_W; c++)
         if (grid[row][c] == '0) row_full = 1'b0;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state         <= ST_IDLE;
         grid          <= '0;
         lk            <= '0;
         lk_idx        <= '0;
         row           <= '0;
         lock_ack      <= 1'b0;
         lock_overrun  <= 1'b0;
         lines_cleared <= '0;
      end else begin
         lock_ack <= 1'b0;
         if (clear_grid) begin
            grid  <= '0;
            state <= ST_IDLE;
         end else begin
            if (lock_req && state != ST_IDLE) lock_overrun <= 1'b1;
            case (state)
               ST_IDLE: if (lock_req) begin
                  lk     <= '{shape: shape_t'(piece_shape), rot: piece_rot,
                              x: piece_x, y: piece_y, color: piece_color};
                  lk_idx <= '0;
                  state  <= ST_LOCK;
               end
               ST_LOCK: begin
                  if (lk_ok) grid[YW'(lk_yi)][XW'(lk_xi)] <= lk.color;
                  lk_idx <= lk_idx + 2'd1;
                  if (lk_idx == 2'd3) begin
                     row   <= YW'(GRID_H - 1);
                     state <= ST_SCAN;
                  end
               end
               ST_SCAN: begin
                  if (row_full) state <= ST_SHIFT;
                  else if (row == '0) begin
                     lock_ack <= 1'b1;
                     state    <= ST_DONE;
                  end else row <= row - 1'b1;
               end
               ST_SHIFT: begin
                  // rescan the same row: it now holds what used to sit above it
                  for (int r = GRID_H - 1; r > 0; r--)
                     if (r <= int'(row)) grid[r] <= grid[r-1];
                  grid[0]       <= '0;
                  lines_cleared <= lines_cleared + 16'd1;
                  state         <= ST_SCAN;
               end
               ST_DONE: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
